// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer.
// Drives an external n-bit ALU one operation per clock and holds the result.
module alu_muldiv_sequencer #(
    parameter int unsigned n = 4,
    parameter int unsigned m = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [n-1:0] opa,
    input  logic [n-1:0] opb,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic         alu_cin,
    output logic [2:0]   alu_ctrl,
    input  logic [n-1:0] alu_f,
    input  logic         alu_cout,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] res_hi,
    output logic [n-1:0] res_lo,
    output logic         div_zero
);

    localparam logic [2:0] CTRL_ADD  = 3'b000;
    localparam logic [2:0] CTRL_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] acc_q, acc_d;     // MUL accumulator / DIV partial remainder
    logic [n-1:0] q_q, q_d;         // MUL multiplier / DIV quotient shift register
    logic [n-1:0] m_q, m_d;         // multiplicand or divisor
    logic [m-1:0] cnt_q, cnt_d;
    logic [n-1:0] res_hi_q, res_hi_d;
    logic [n-1:0] res_lo_q, res_lo_d;
    logic         div_zero_q, div_zero_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [n-1:0] alu_a_q, alu_a_d;
    logic [n-1:0] alu_b_q, alu_b_d;
    logic         alu_cin_q, alu_cin_d;
    logic [2:0]   alu_ctrl_q, alu_ctrl_d;

    logic         cout_used;
    logic         div_ok;
    logic [n-1:0] div_s_hi;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        div_zero_d = div_zero_q;
        cout_used  = 1'b0;
        div_ok     = 1'b0;
        div_s_hi   = {acc_q[n-2:0], q_q[n-1]};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    cnt_d      = m'(n - 1);
                    acc_d      = '0;
                    if (op) begin
                        m_d = opb;
                        q_d = opa;
                        if (opb == '0) begin
                            state_d    = DONE;
                            res_hi_d   = opa;
                            res_lo_d   = '1;
                            div_zero_d = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end else begin
                        m_d     = opa;
                        q_d     = opb;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                // Carry only matters when an add actually happened.
                cout_used = q_q[0] & alu_cout;
                acc_d     = {cout_used, alu_f[n-1:1]};
                q_d       = {alu_f[0], q_q[n-1:1]};
                cnt_d     = cnt_q - m'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    res_hi_d = acc_d;
                    res_lo_d = q_d;
                end
            end
            DIV: begin
                // Subtract succeeds if a bit was shifted out or no borrow occurred.
                div_ok = acc_q[n-1] | alu_cout;
                acc_d  = div_ok ? alu_f : div_s_hi;
                q_d    = {q_q[n-2:0], div_ok};
                cnt_d  = cnt_q - m'(1);
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    res_hi_d = acc_d;
                    res_lo_d = q_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        // ALU drive is registered, so it is derived from the next-cycle state.
        alu_a_d    = '0;
        alu_b_d    = '0;
        alu_cin_d  = 1'b0;
        alu_ctrl_d = CTRL_PASS;
        if (state_d == MUL) begin
            alu_a_d    = acc_d;
            alu_b_d    = m_d;
            alu_ctrl_d = q_d[0] ? CTRL_ADD : CTRL_PASS;
        end else if (state_d == DIV) begin
            alu_a_d    = {acc_d[n-2:0], q_d[n-1]};
            alu_b_d    = m_d;
            alu_cin_d  = 1'b1;
            alu_ctrl_d = CTRL_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_ctrl_q <= CTRL_PASS;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_ctrl_q <= alu_ctrl_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_cin  = alu_cin_q;
    assign alu_ctrl = alu_ctrl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign res_hi   = res_hi_q;
    assign res_lo   = res_lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural 4-bit ALU beside it.
`timescale 1ns/1ps
module tb_alu_muldiv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [3:0] opa, opb;
    logic [3:0] alu_a, alu_b, alu_f;
    logic       alu_cin, alu_cout;
    logic [2:0] alu_ctrl;
    logic       busy, done, div_zero;
    logic [3:0] res_hi, res_lo;

    int n_vec = 0;
    int n_mis = 0;

    alu_muldiv_sequencer #(.n(4), .m(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
        .alu_f(alu_f), .alu_cout(alu_cout), .busy(busy), .done(done),
        .res_hi(res_hi), .res_lo(res_lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // ALU model: ctrl 000 adds (cin=1 inverts B for subtract), ctrl 111 passes A.
    logic [4:0] alu_sum;
    always_comb begin
        alu_sum = 5'd0;
        if (alu_ctrl == 3'b000)
            alu_sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + {4'd0, alu_cin};
        else if (alu_ctrl == 3'b111)
            alu_sum = {1'b0, alu_a};
        alu_f    = alu_sum[3:0];
        alu_cout = alu_sum[4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op, traces the ALU drive each iteration, then checks results.
    task automatic run_op(input logic o, input logic [3:0] a, input logic [3:0] b,
                          input int lat, input logic [3:0] ehi, input logic [3:0] elo,
                          input logic edz);
        int cyc;
        int it;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0; opa = 4'($urandom); opb = 4'($urandom);
        cyc = 1;
        it  = 0;
        while (!done && cyc < 40) begin
            if (!o && it < 4)
                chk("mul_ctrl", 32'(alu_ctrl), b[it] ? 32'd0 : 32'd7);
            else if (o)
                chk("div_ctrl_cin", 32'({alu_ctrl, alu_cin}), 32'h1);
            it++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("done", 32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("res_hi", 32'(res_hi), 32'(ehi));
        chk("res_lo", 32'(res_lo), 32'(elo));
        chk("div_zero", 32'(div_zero), 32'(edz));
        if (o && b == 4'd0)
            chk("dz_ctrl", 32'(alu_ctrl), 32'd7);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_clr", 32'(busy), 32'd0);
        chk("res_held", 32'({res_hi, res_lo}), 32'({ehi, elo}));
    endtask

    initial begin
        int dones;
        int cyc;
        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = 4'd0; opb = 4'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", 32'({res_hi, res_lo}), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_ctrl}), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 4'hD, 4'hB, 5, 4'h8, 4'hF, 1'b0);
        run_op(1'b0, 4'hF, 4'hF, 5, 4'hE, 4'h1, 1'b0);
        run_op(1'b0, 4'h0, 4'h9, 5, 4'h0, 4'h0, 1'b0);
        run_op(1'b0, 4'h7, 4'h6, 5, 4'h2, 4'hA, 1'b0);
        run_op(1'b1, 4'hD, 4'h3, 5, 4'h1, 4'h4, 1'b0);
        run_op(1'b1, 4'hF, 4'h1, 5, 4'h0, 4'hF, 1'b0);
        run_op(1'b1, 4'h9, 4'h0, 1, 4'h9, 4'hF, 1'b1);
        run_op(1'b1, 4'hE, 4'h4, 5, 4'h2, 4'h3, 1'b0);

        // start pulsed mid-multiply must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 4'hD; opb = 4'hB;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 4'h9; opb = 4'h0;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                chk("ign_res", 32'({res_hi, res_lo}), 32'h8F);
                chk("ign_dz", 32'(div_zero), 32'd0);
            end
            @(negedge clk);
        end
        chk("ign_done_count", 32'(dones), 32'd1);

        // start while done is high must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 4'h2; opb = 4'h3;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("dc_latency", 32'(cyc), 32'd5);
        start = 1'b1; op = 1'b1; opa = 4'h5; opb = 4'h0;
        @(negedge clk);
        start = 1'b0;
        chk("dc_busy", 32'(busy), 32'd0);
        chk("dc_res", 32'({res_hi, res_lo, div_zero}), 32'({8'h06, 1'b0}));

        // reset during the second iteration aborts the op
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 4'hF; opb = 4'hF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_res", 32'({res_hi, res_lo, div_zero}), 32'd0);
        chk("arst_alu", 32'({alu_a, alu_b, alu_cin, alu_ctrl}), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        chk("arst_no_done", 32'(dones), 32'd0);
        run_op(1'b0, 4'h7, 4'h6, 5, 4'h2, 4'hA, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
